// File: rtl/scr_stack_ctrl.sv
// scr_stack_ctrl -- command sequencer in front of the scratch RAM (ScrRam).
// Owns the stack pointer and turns LD/ST/PUSH/POP/SP_LD/SP_RD commands into
// one-cycle RAM accesses. Every command takes three cycles: the accept edge,
// one ACCESS cycle, and one RESP cycle.
//
// Optional feature: define STACK_GUARD_EN to add an occupancy counter that
// rejects PUSH on a full stack and POP on an empty stack (rsp_err=1).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                0 LD, 1 ST, 2 PUSH, 3 POP, 4 SP_LD, 5 SP_RD, 6/7 illegal
//   cmd_addr, cmd_data    direct address / new SP, write data
//   rsp_valid             one-cycle completion pulse
//   rsp_data, rsp_err     response payload, held until the next response
//   sp_out                current stack pointer
//   scr_addr/scr_din/scr_wr/scr_dout   ScrRam port (asynchronous read)
module scr_stack_ctrl #(
  parameter int AW       = 8,
  parameter int DW       = 10,
  parameter int SP_RESET = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [AW-1:0] sp_out,
  output logic [AW-1:0] scr_addr,
  output logic [DW-1:0] scr_din,
  output logic          scr_wr,
  input  logic [DW-1:0] scr_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [2:0] {
    OP_LD    = 3'd0,
    OP_ST    = 3'd1,
    OP_PUSH  = 3'd2,
    OP_POP   = 3'd3,
    OP_SP_LD = 3'd4,
    OP_SP_RD = 3'd5
  } op_t;

  state_t        r_state, w_next;
  logic [2:0]    r_op;
  logic          r_rej;
  logic [AW-1:0] r_sp;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic          r_wr;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_err;

  logic          w_accept;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW-1:0] w_sp_dec;
  logic [AW-1:0] w_sp_inc;
  logic [DW-1:0] w_sp_ext;

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_sp_dec = r_sp - AW'(1);
  assign w_sp_inc = r_sp + AW'(1);
  // SP_RD never moves SP, so SP during ACCESS equals SP at accept.
  assign w_sp_ext = DW'(r_sp);

`ifdef STACK_GUARD_EN
  logic [AW:0] r_occ;

  assign w_push_ok = (r_occ != {1'b1, {AW{1'b0}}});
  assign w_pop_ok  = (r_occ != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (w_accept) begin
      if (cmd_op == OP_SP_LD)                 r_occ <= '0;
      else if (cmd_op == OP_PUSH && w_push_ok) r_occ <= r_occ + (AW+1)'(1);
      else if (cmd_op == OP_POP && w_pop_ok)   r_occ <= r_occ - (AW+1)'(1);
    end
  end
`else
  assign w_push_ok = 1'b1;
  assign w_pop_ok  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = S_ACCESS;
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_rej      <= 1'b0;
      r_sp       <= AW'(SP_RESET);
      r_addr     <= '0;
      r_din      <= '0;
      r_wr       <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_op  <= cmd_op;
      r_rej <= 1'b0;
      case (cmd_op)
        OP_LD: r_addr <= cmd_addr;
        OP_ST: begin
          r_addr <= cmd_addr;
          r_din  <= cmd_data;
          r_wr   <= 1'b1;
        end
        OP_PUSH: begin
          if (w_push_ok) begin
            r_addr <= w_sp_dec;
            r_din  <= cmd_data;
            r_wr   <= 1'b1;
            r_sp   <= w_sp_dec;
          end else begin
            r_rej <= 1'b1;
          end
        end
        OP_POP: begin
          if (w_pop_ok) begin
            r_addr <= r_sp;
            r_sp   <= w_sp_inc;
          end else begin
            r_rej <= 1'b1;
          end
        end
        OP_SP_LD: r_sp <= cmd_addr;
        OP_SP_RD: ;
        default:  r_rej <= 1'b1;
      endcase
    end else if (r_state == S_ACCESS) begin
      r_wr      <= 1'b0;
      r_rsp_err <= r_rej;
      case (r_op)
        OP_LD:    r_rsp_data <= scr_dout;
        OP_POP:   r_rsp_data <= r_rej ? '0 : scr_dout;
        OP_SP_RD: r_rsp_data <= w_sp_ext;
        default:  r_rsp_data <= '0;
      endcase
    end
  end

  assign sp_out   = r_sp;
  assign scr_addr = r_addr;
  assign scr_din  = r_din;
  assign scr_wr   = r_wr;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Directed bench for scr_stack_ctrl with a behavioural ScrRam model
// (asynchronous read, write on the rising edge while scr_wr is high).
module tb_scr_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_addr = '0;
  logic [9:0] cmd_data = '0;
  logic       rsp_valid;
  logic [9:0] rsp_data;
  logic       rsp_err;
  logic [7:0] sp_out;
  logic [7:0] scr_addr;
  logic [9:0] scr_din;
  logic       scr_wr;
  logic [9:0] scr_dout;

  logic [9:0] mem [256];

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [5:0] ready_seq;
  logic [5:0] valid_seq;

  always #5 clk = ~clk;

  scr_stack_ctrl #(.AW(8), .DW(10), .SP_RESET(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sp_out(sp_out),
    .scr_addr(scr_addr), .scr_din(scr_din), .scr_wr(scr_wr), .scr_dout(scr_dout)
  );

  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) if (scr_wr) mem[scr_addr] <= scr_din;
  assign scr_dout = mem[scr_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge in IDLE; returns 1 time unit into ACCESS.
  task automatic issue(input logic [2:0] op, input logic [7:0] addr, input logic [9:0] data);
    chk("ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called in ACCESS; steps through RESP back to IDLE.
  task automatic finish_rsp(input string tag, input logic [9:0] exp_data, input logic exp_err);
    tick();
    chk({tag, "_rspv"}, rsp_valid, 1'b1);
    chk({tag, "_data"}, rsp_data, exp_data);
    chk({tag, "_err"},  rsp_err, exp_err);
    chk({tag, "_wr_resp"}, scr_wr, 1'b0);
    chk({tag, "_rdy_resp"}, cmd_ready, 1'b0);
    tick();
    chk({tag, "_rspv_end"}, rsp_valid, 1'b0);
    chk({tag, "_data_hold"}, rsp_data, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    tick(); tick();
    chk("rst_sp", sp_out, 8'h00);
    chk("rst_wr", scr_wr, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_rspv", rsp_valid, 1'b0);
    chk("rst_rspd", rsp_data, 10'h000);
    chk("rst_addr", scr_addr, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    tick();

    issue(3'd0, 8'h10, 10'h000);
    chk("ld10_addr", scr_addr, 8'h10);
    chk("ld10_wr", scr_wr, 1'b0);
    finish_rsp("ld10", 10'h000, 1'b0);

    // 2: store then load
    issue(3'd1, 8'h05, 10'h2A5);
    chk("st_wr", scr_wr, 1'b1);
    chk("st_addr", scr_addr, 8'h05);
    chk("st_din", scr_din, 10'h2A5);
    finish_rsp("st", 10'h000, 1'b0);
    chk("st_mem", mem[5], 10'h2A5);
    issue(3'd0, 8'h05, 10'h000);
    finish_rsp("ld05", 10'h2A5, 1'b0);

    // 3: push/push/pop/pop with wrap from sp=0
    issue(3'd2, 8'h00, 10'h111);
    chk("push1_addr", scr_addr, 8'hFF);
    chk("push1_wr", scr_wr, 1'b1);
    chk("push1_din", scr_din, 10'h111);
    chk("push1_sp", sp_out, 8'hFF);
    finish_rsp("push1", 10'h000, 1'b0);
    issue(3'd2, 8'h00, 10'h222);
    chk("push2_addr", scr_addr, 8'hFE);
    chk("push2_sp", sp_out, 8'hFE);
    finish_rsp("push2", 10'h000, 1'b0);
    issue(3'd3, 8'h00, 10'h000);
    chk("pop1_addr", scr_addr, 8'hFE);
    chk("pop1_wr", scr_wr, 1'b0);
    chk("pop1_sp", sp_out, 8'hFF);
    finish_rsp("pop1", 10'h222, 1'b0);
    issue(3'd3, 8'h00, 10'h000);
    chk("pop2_addr", scr_addr, 8'hFF);
    chk("pop2_sp", sp_out, 8'h00);
    finish_rsp("pop2", 10'h111, 1'b0);

    // 4: cmd_valid held for 6 cycles
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_addr  = 8'h05;
    for (int c = 5; c >= 0; c--) begin
      ready_seq[c] = cmd_ready;
      valid_seq[c] = rsp_valid;
      tick();
    end
    cmd_valid = 1'b0;
    chk("hold_ready_seq", ready_seq, 6'b100100);
    chk("hold_rspv_seq", valid_seq, 6'b001001);
    chk("hold_data", rsp_data, 10'h2A5);

    // 5: reset during a ST ACCESS cycle
    issue(3'd1, 8'h05, 10'h3C3);
    chk("rstmid_wr_before", scr_wr, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_wr_after", scr_wr, 1'b0);
    chk("rstmid_ready", cmd_ready, 1'b1);
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rstmid_mem", mem[5], 10'h2A5);
    issue(3'd0, 8'h05, 10'h000);
    finish_rsp("rstmid_ld", 10'h2A5, 1'b0);
`ifdef STACK_GUARD_EN
    issue(3'd3, 8'h00, 10'h000);
    chk("guard_pop_wr", scr_wr, 1'b0);
    chk("guard_pop_sp", sp_out, 8'h00);
    finish_rsp("guard_pop", 10'h000, 1'b1);
    chk("guard_pop_sp_end", sp_out, 8'h00);
`endif

    // 6: SP load/read and an illegal op
    issue(3'd4, 8'h80, 10'h000);
    chk("spld_sp", sp_out, 8'h80);
    chk("spld_wr", scr_wr, 1'b0);
    finish_rsp("spld", 10'h000, 1'b0);
    issue(3'd5, 8'h00, 10'h000);
    finish_rsp("sprd", 10'h080, 1'b0);
    issue(3'd7, 8'h33, 10'h155);
    chk("ill_wr", scr_wr, 1'b0);
    chk("ill_sp", sp_out, 8'h80);
    finish_rsp("ill", 10'h000, 1'b1);
    chk("ill_mem", mem[8'h33], 10'h000);
    issue(3'd0, 8'h7F, 10'h000);
    finish_rsp("ld_after_ill", 10'h000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
